// File: rtl/axis_cntr_checker_if.sv
// AXI4-Stream data channel bundle used between a counter source and its checker.
// Latency: none; this is wiring only.
// Backpressure: tready travels slave -> master; valid/data travel master -> slave.
//
// Ports (signals):
//   tdata  : stream word, AXIS_TDATA_WIDTH bits
//   tvalid : word present
//   tready : sink accepts the word this cycle
interface axis_cntr_checker_if #(
  parameter int AXIS_TDATA_WIDTH = 32
) ();
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_cntr_checker.sv
// Sink-side checker for an incrementing AXI4-Stream count: locks on the first word, then counts mismatches and skipped values.
// Latency: a beat in cycle N shows on every sts_* output in cycle N+1; tready is combinational.
// Backpressure: never stalls on its own; tready simply follows cfg_tready (forced low in reset).
//
// Ports:
//   aclk, aresetn    : clock, synchronous active-low reset
//   cfg_clear        : while high, statistics are held at zero and the checker is unlocked
//   cfg_tready       : copied to s_axis.tready
//   s_axis           : stream sink (tdata, tvalid in; tready out)
//   sts_locked       : a reference word has been accepted
//   sts_err_flag     : sticky, at least one mismatch since clear/reset
//   sts_word_cnt     : accepted words, saturating
//   sts_err_cnt      : mismatching words, saturating
//   sts_gap_sum      : sum of skipped values (modular), saturating
//   sts_first_exp    : expected value at the first mismatch
//   sts_first_got    : received value at the first mismatch
module axis_cntr_checker #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int STS_WIDTH        = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_clear,
  input  logic                   cfg_tready,
  axis_cntr_checker_if.slave     s_axis,
  output logic                   sts_locked,
  output logic                   sts_err_flag,
  output logic [STS_WIDTH-1:0]   sts_word_cnt,
  output logic [STS_WIDTH-1:0]   sts_err_cnt,
  output logic [STS_WIDTH-1:0]   sts_gap_sum,
  output logic [CNTR_WIDTH-1:0]  sts_first_exp,
  output logic [CNTR_WIDTH-1:0]  sts_first_got
);

  // Gap accumulation is done one bit wider than the wider of the gap and the
  // accumulator, so both the sum overflow and a gap that does not fit in
  // STS_WIDTH bits show up as "greater than the STS all-ones value".
  localparam int GW = ((CNTR_WIDTH > STS_WIDTH) ? CNTR_WIDTH : STS_WIDTH) + 1;
  localparam logic [GW-1:0] STS_MAX_EXT = {{(GW-STS_WIDTH){1'b0}}, {STS_WIDTH{1'b1}}};

  typedef enum logic {
    SEEK  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [CNTR_WIDTH-1:0] r_exp;
  logic                  r_err_flag;
  logic [STS_WIDTH-1:0]  r_word_cnt;
  logic [STS_WIDTH-1:0]  r_err_cnt;
  logic [STS_WIDTH-1:0]  r_gap_sum;
  logic [CNTR_WIDTH-1:0] r_first_exp;
  logic [CNTR_WIDTH-1:0] r_first_got;

  logic                  w_beat;
  logic [CNTR_WIDTH-1:0] w_d;
  logic                  w_match;
  logic                  w_lock_beat;
  logic                  w_err_beat;
  logic [CNTR_WIDTH-1:0] w_gap;
  logic [GW-1:0]         w_gap_sum_wide;
  logic [STS_WIDTH-1:0]  w_gap_sum_nxt;
  logic [STS_WIDTH-1:0]  w_word_cnt_nxt;
  logic [STS_WIDTH-1:0]  w_err_cnt_nxt;
  logic                  w_unused_tdata;

  // Handshake: the sink is ready whenever configured, except in reset.
  assign s_axis.tready = cfg_tready & aresetn;
  assign w_beat        = s_axis.tvalid & s_axis.tready;

  // Only the low CNTR_WIDTH bits carry the count; the rest are ignored.
  assign w_d            = s_axis.tdata[CNTR_WIDTH-1:0];
  assign w_unused_tdata = ^s_axis.tdata;

  assign w_match = (w_d == r_exp);

  // Modular distance from the expected value; a backward jump wraps to a
  // large positive gap, which is the intended reading.
  assign w_gap = w_d - r_exp;

  assign w_gap_sum_wide = {{(GW-STS_WIDTH){1'b0}}, r_gap_sum}
                        + {{(GW-CNTR_WIDTH){1'b0}}, w_gap};
  assign w_gap_sum_nxt  = (w_gap_sum_wide > STS_MAX_EXT) ? {STS_WIDTH{1'b1}}
                                                         : w_gap_sum_wide[STS_WIDTH-1:0];

  assign w_word_cnt_nxt = (&r_word_cnt) ? r_word_cnt : r_word_cnt + STS_WIDTH'(1);
  assign w_err_cnt_nxt  = (&r_err_cnt)  ? r_err_cnt  : r_err_cnt  + STS_WIDTH'(1);

  // Next-state and per-beat classification.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_beat = 1'b0;
    w_err_beat  = 1'b0;
    case (r_state)
      SEEK: begin
        if (w_beat) begin
          w_lock_beat = 1'b1;
          w_state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (w_beat && !w_match) begin
          w_err_beat = 1'b1;
        end
      end
    endcase
  end

  // Reset and clear share one path: both return to SEEK with zeroed status.
  // Because clear wins over the beat, a word arriving during clear is dropped
  // and cannot become the reference.
  always_ff @(posedge aclk) begin
    if (!aresetn || cfg_clear) begin
      r_state     <= SEEK;
      r_exp       <= '0;
      r_err_flag  <= 1'b0;
      r_word_cnt  <= '0;
      r_err_cnt   <= '0;
      r_gap_sum   <= '0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_beat) begin
        // Always resync to the received word, matched or not, so one glitch
        // produces one error rather than a run of them.
        r_exp      <= w_d + CNTR_WIDTH'(1);
        r_word_cnt <= w_word_cnt_nxt;
      end
      if (w_err_beat) begin
        r_err_cnt <= w_err_cnt_nxt;
        r_gap_sum <= w_gap_sum_nxt;
        if (!r_err_flag) begin
          r_first_exp <= r_exp;
          r_first_got <= w_d;
          r_err_flag  <= 1'b1;
        end
      end
    end
  end

  // State encoding makes TRACK itself the registered lock indication.
  assign sts_locked    = (r_state == TRACK);
  assign sts_err_flag  = r_err_flag;
  assign sts_word_cnt  = r_word_cnt;
  assign sts_err_cnt   = r_err_cnt;
  assign sts_gap_sum   = r_gap_sum;
  assign sts_first_exp = r_first_exp;
  assign sts_first_got = r_first_got;

endmodule

// File: tb/tb_axis_cntr_checker.sv
// Bench for axis_cntr_checker: three instances (32/32/32, CNTR=8, CNTR=8 STS=4) share one stimulus.
module tb_axis_cntr_checker;

  logic        aclk;
  logic        aresetn;
  logic        cfg_clear;
  logic        cfg_tready;
  logic [31:0] tdata;
  logic        tvalid;

  int total;
  int bad;

  axis_cntr_checker_if #(.AXIS_TDATA_WIDTH(32)) if32 ();
  axis_cntr_checker_if #(.AXIS_TDATA_WIDTH(32)) if8  ();
  axis_cntr_checker_if #(.AXIS_TDATA_WIDTH(32)) if4  ();

  assign if32.tdata  = tdata;
  assign if32.tvalid = tvalid;
  assign if8.tdata   = tdata;
  assign if8.tvalid  = tvalid;
  assign if4.tdata   = tdata;
  assign if4.tvalid  = tvalid;

  logic        lk32, ef32;
  logic [31:0] wc32, ec32, gs32, fe32, fg32;
  logic        lk8, ef8;
  logic [31:0] wc8, ec8, gs8;
  logic [7:0]  fe8, fg8;
  logic        lk4, ef4;
  logic [3:0]  wc4, ec4, gs4;
  logic [7:0]  fe4, fg4;

  axis_cntr_checker #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32), .STS_WIDTH(32)) u_dut32 (
    .aclk(aclk), .aresetn(aresetn), .cfg_clear(cfg_clear), .cfg_tready(cfg_tready),
    .s_axis(if32.slave),
    .sts_locked(lk32), .sts_err_flag(ef32), .sts_word_cnt(wc32), .sts_err_cnt(ec32),
    .sts_gap_sum(gs32), .sts_first_exp(fe32), .sts_first_got(fg32)
  );

  axis_cntr_checker #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(8), .STS_WIDTH(32)) u_dut8 (
    .aclk(aclk), .aresetn(aresetn), .cfg_clear(cfg_clear), .cfg_tready(cfg_tready),
    .s_axis(if8.slave),
    .sts_locked(lk8), .sts_err_flag(ef8), .sts_word_cnt(wc8), .sts_err_cnt(ec8),
    .sts_gap_sum(gs8), .sts_first_exp(fe8), .sts_first_got(fg8)
  );

  axis_cntr_checker #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(8), .STS_WIDTH(4)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn), .cfg_clear(cfg_clear), .cfg_tready(cfg_tready),
    .s_axis(if4.slave),
    .sts_locked(lk4), .sts_err_flag(ef4), .sts_word_cnt(wc4), .sts_err_cnt(ec4),
    .sts_gap_sum(gs4), .sts_first_exp(fe4), .sts_first_got(fg4)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        clr;
    logic        vld;
    logic        rdy;
    logic [7:0]  dat;
    logic        locked;
    logic        ef;
    int unsigned word;
    int unsigned err;
    int unsigned gap;
    logic [7:0]  fe;
    logic [7:0]  fg;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    tvalid    = 1'b0;
    tick();
    cfg_clear = 1'b0;
  endtask

  // Free-running source model: one value per cycle regardless of tready.
  logic [31:0] v;
  task automatic src(input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      cfg_tready = rdy;
      tdata      = v;
      tvalid     = 1'b1;
      tick();
      v = v + 32'd1;
    end
    tvalid     = 1'b0;
    cfg_tready = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // clr vld rdy dat | locked ef word err gap fe fg  (CNTR_WIDTH=8 instance)
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'hFD, 1'b1, 1'b0, 1, 0, 0,     8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b0, 2, 0, 0,     8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3, 0, 0,     8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 4, 0, 0,     8'h00, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 5, 0, 0,     8'h00, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 5, 0, 0,     8'h00, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 5, 0, 0,     8'h00, 8'h00};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 0, 0, 0,     8'h00, 8'h00};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1, 0, 0,     8'h00, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 2, 0, 0,     8'h00, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 3, 1, 'hF3,  8'h12, 8'h05};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 4, 1, 'hF3,  8'h12, 8'h05};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1, 5, 1, 'hF3,  8'h12, 8'h05};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 6, 2, 'hFA,  8'h12, 8'h05};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 7, 3, 'h1F9, 8'h12, 8'h05};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 8, 3, 'h1F9, 8'h12, 8'h05};

    aresetn    = 1'b0;
    cfg_clear  = 1'b0;
    cfg_tready = 1'b1;
    tdata      = '0;
    tvalid     = 1'b0;
    v          = '0;

    // Reset state
    tick();
    tick();
    chk("rst_tready", if32.tready, 1'b0);
    chk("rst_locked", lk32, 1'b0);
    chk("rst_err_flag", ef32, 1'b0);
    chk("rst_word_cnt", wc32, 0);
    chk("rst_err_cnt", ec32, 0);
    chk("rst_gap_sum", gs32, 0);
    chk("rst_first_exp", fe32, 0);
    chk("rst_first_got", fg32, 0);
    aresetn = 1'b1;
    #1;
    chk("tready_follow_cfg", if32.tready, 1'b1);
    cfg_tready = 1'b0;
    #1;
    chk("tready_cfg_low", if32.tready, 1'b0);
    cfg_tready = 1'b1;
    tick();
    chk("idle_unlocked", lk32, 1'b0);

    // Contiguous 0..999
    v = 32'd0;
    cfg_tready = 1'b1;
    tdata  = v;
    tvalid = 1'b1;
    tick();
    chk("contig_locked_n1", lk32, 1'b1);
    chk("contig_word_n1", wc32, 1);
    v = 32'd1;
    src(999, 1'b1);
    chk("contig_word", wc32, 1000);
    chk("contig_err", ec32, 0);
    chk("contig_gap", gs32, 0);
    chk("contig_locked", lk32, 1'b1);
    chk("contig_err_flag", ef32, 1'b0);

    // Dropped words via tready
    do_clear();
    v = 32'd100;
    src(10, 1'b1);
    src(5, 1'b0);
    src(10, 1'b1);
    chk("drop5_err", ec32, 1);
    chk("drop5_gap", gs32, 5);
    chk("drop5_fexp", fe32, 110);
    chk("drop5_fgot", fg32, 115);
    chk("drop5_flag", ef32, 1'b1);
    src(3, 1'b0);
    src(5, 1'b1);
    chk("drop3_err", ec32, 2);
    chk("drop3_gap", gs32, 8);
    chk("drop3_fexp", fe32, 110);
    chk("drop3_fgot", fg32, 115);
    chk("drop3_word", wc32, 25);

    // Clear mid-stream with a beat present in the clear cycle
    cfg_clear = 1'b1;
    tdata     = 32'd133;
    tvalid    = 1'b1;
    tick();
    cfg_clear = 1'b0;
    chk("clr_locked", lk32, 1'b0);
    chk("clr_word", wc32, 0);
    chk("clr_err", ec32, 0);
    chk("clr_gap", gs32, 0);
    chk("clr_flag", ef32, 1'b0);
    chk("clr_fexp", fe32, 0);
    chk("clr_fgot", fg32, 0);
    tdata = 32'd7;
    tick();
    tvalid = 1'b0;
    chk("clr_relock", lk32, 1'b1);
    chk("clr_relock_word", wc32, 1);
    chk("clr_relock_err", ec32, 0);

    // Reset mid-stream with valid held
    do_clear();
    v = 32'd600;
    src(5, 1'b1);
    chk("prerst_word", wc32, 5);
    aresetn = 1'b0;
    tdata   = 32'd605;
    tvalid  = 1'b1;
    #1;
    chk("rst_mid_tready", if32.tready, 1'b0);
    tick();
    chk("rst_mid_locked", lk32, 1'b0);
    chk("rst_mid_word", wc32, 0);
    aresetn = 1'b1;
    tdata   = 32'd900;
    tick();
    chk("rst_relock", lk32, 1'b1);
    chk("rst_relock_word", wc32, 1);
    tdata = 32'd901;
    tick();
    tvalid = 1'b0;
    chk("rst_next_word", wc32, 2);
    chk("rst_next_err", ec32, 0);
    chk("rst_next_flag", ef32, 1'b0);

    // Table: 8-bit wrap, ignored beats, clear, mismatch incl. backward jump
    do_clear();
    for (int i = 0; i < 16; i++) begin
      cfg_clear  = vecs[i].clr;
      tvalid     = vecs[i].vld;
      cfg_tready = vecs[i].rdy;
      tdata      = {24'h0, vecs[i].dat};
      tick();
      chk($sformatf("v%0d_locked", i), lk8, vecs[i].locked);
      chk($sformatf("v%0d_flag", i), ef8, vecs[i].ef);
      chk($sformatf("v%0d_word", i), wc8, vecs[i].word);
      chk($sformatf("v%0d_err", i), ec8, vecs[i].err);
      chk($sformatf("v%0d_gap", i), gs8, vecs[i].gap);
      chk($sformatf("v%0d_fexp", i), fe8, vecs[i].fe);
      chk($sformatf("v%0d_fgot", i), fg8, vecs[i].fg);
    end
    cfg_clear  = 1'b0;
    tvalid     = 1'b0;
    cfg_tready = 1'b1;

    // STS_WIDTH=4 saturation: stride-2 stream, every word after the first is off by one
    do_clear();
    for (int i = 0; i < 21; i++) begin
      tdata  = 32'(2 * i);
      tvalid = 1'b1;
      tick();
      if (i == 10) begin
        chk("sat_mid_word", wc4, 4'hB);
        chk("sat_mid_err", ec4, 4'hA);
        chk("sat_mid_gap", gs4, 4'hA);
      end
    end
    tvalid = 1'b0;
    chk("sat_word", wc4, 4'hF);
    chk("sat_err", ec4, 4'hF);
    chk("sat_gap", gs4, 4'hF);
    chk("sat_flag", ef4, 1'b1);
    chk("sat_fexp", fe4, 8'h01);
    chk("sat_fgot", fg4, 8'h02);

    // A single gap wider than the 4-bit accumulator clamps
    do_clear();
    tdata  = 32'h00;
    tvalid = 1'b1;
    tick();
    tdata = 32'h40;
    tick();
    tvalid = 1'b0;
    chk("biggap_err", ec4, 4'h1);
    chk("biggap_gap", gs4, 4'hF);
    chk("biggap_word", wc4, 4'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_cntr_checker.md
# axis_cntr_checker

Sink-side checker for the free-running AXI4-Stream counter source. Consumes the incrementing count stream, locks onto the first accepted word, and verifies that every later accepted word equals the previous accepted word + 1 (mod 2^CNTR_WIDTH). It reports word, error and skipped-word statistics through registered status ports for the PS/status register bank. It also drives s_axis_tready from a config bit. The source ignores backpressure, so deasserting tready is the standard way to provoke and measure dropped words.

## Interface

- AXIS_TDATA_WIDTH, 32, input stream width
- CNTR_WIDTH, 32, compared width; low CNTR_WIDTH bits of tdata, ≤ AXIS_TDATA_WIDTH
- STS_WIDTH, 32, width of every statistics counter

Reset `aresetn` is synchronous, active-low; the clock is `aclk`.

- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- cfg_clear  in  1  level/pulse; while high, holds statistics cleared and checker unlocked
- cfg_tready  in  1  level copied combinationally to s_axis_tready
- s_axis_tdata  in  AXIS_TDATA_WIDTH  counter word
- s_axis_tvalid  in  1  valid
- s_axis_tready  out  1  = cfg_tready & aresetn
- sts_locked  out  1  high once a reference word has been accepted
- sts_err_flag  out  1  sticky: at least one mismatch since clear
- sts_word_cnt  out  STS_WIDTH  accepted words, saturating
- sts_err_cnt  out  STS_WIDTH  mismatching words, saturating
- sts_gap_sum  out  STS_WIDTH  sum of skipped values, saturating
- sts_first_exp  out  CNTR_WIDTH  expected value at first mismatch
- sts_first_got  out  CNTR_WIDTH  received value at first mismatch

## Operation

- Beat = s_axis_tvalid & s_axis_tready. Data is used only on a beat. The checker never stalls on its own.
- Compared value d = s_axis_tdata[CNTR_WIDTH-1:0]. The expected register is exp, CNTR_WIDTH bits.
- State machine has two states, SEEK and TRACK. Reset and cfg_clear both go to SEEK.
- SEEK, on a beat:
  - exp <= d+1 (mod 2^CNTR_WIDTH)
  - word_cnt += 1
  - go to TRACK; sts_locked = 1
  - the first word is never an error
- TRACK, beat with d == exp:
  - word_cnt += 1
  - exp <= d+1
- TRACK, beat with d != exp:
  - word_cnt += 1
  - err_cnt += 1
  - gap_sum += (d − exp) mod 2^CNTR_WIDTH, zero-extended/truncated-saturated to STS_WIDTH
  - exp <= d+1 (resync)
  - if err_flag is 0: capture first_exp = exp and first_got = d, then set err_flag
  - later mismatches do not change first_exp/first_got
- Wrap: d = 2^CNTR_WIDTH−1 followed by 0 is correct, not an error.
- Backward jump (d < exp) counts as an error. Its gap is the modular difference, e.g. CNTR_WIDTH=8, exp=0x10, d=0x0F → gap 0xFF.
- Saturation: every STS counter sticks at all-ones. Gap addition clamps to all-ones on overflow.
- cfg_clear priority is reset > cfg_clear > beat. A beat during cfg_clear is discarded: not counted, not used for lock.
- tready low: the source keeps counting, so the next accepted word shows a gap equal to the number of dropped words.

## Timing

- All sts_* outputs are registered. Reset value is 0 for every one: locked 0, err_flag 0, counters 0, first_* 0.
- A beat in cycle N is reflected on sts_* in cycle N+1.
- s_axis_tready is combinational from cfg_tready. It is 0 during reset.
- cfg_clear takes effect at the next edge. The first beat after cfg_clear deasserts re-locks.
- Reset mid-stream has the same effect as clear: the first beat after reset releases is the new reference.

## Test plan

- Contiguous stream 0..999 with cfg_tready=1 → word_cnt=1000, err_cnt=0, gap_sum=0, locked=1 one cycle after first beat, err_flag=0.
- cfg_tready low for 5 cycles mid-stream while source counts → err_cnt=1, gap_sum=5, first_exp/first_got differ by 5. Then drop for 3 cycles → err_cnt=2, gap_sum=8, first_* unchanged.
- CNTR_WIDTH=8, stream 0xFD,0xFE,0xFF,0x00,0x01 → err_cnt=0, word_cnt=5.
- CNTR_WIDTH=8, inject 0x10,0x11,0x05 → err_cnt=1, gap_sum=0xF3, first_exp=0x12, first_got=0x05. Next word 0x06 is correct.
- STS_WIDTH=4, 20 mismatching beats → err_cnt=0xF and word_cnt=0xF, both held. gap_sum is saturated at 0xF.
- Assert cfg_clear for 1 cycle, or aresetn low, mid-stream with a beat in that cycle → all sts_*=0 next cycle, beat ignored. The next beat re-locks with no error.
